// File: rtl/elevator_ctrl.sv
// SCAN-order elevator controller: latches floor calls, steps the car one floor per
// timed MOVE, and holds the door for a reloadable dwell.
module elevator_ctrl #(
  parameter int FLOORS      = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] button,
  output logic [FLOORS-1:0] floor,
  output logic [FLOORS-1:0] pending,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open
);

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_MOVE = TW'(MOVE_CYCLES);
  localparam logic [TW-1:0] T_DOOR = TW'(DOOR_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t            state_q, state_d;
  logic [FLOORS-1:0] floor_q, floor_d;
  logic [FLOORS-1:0] pend_q,  pend_d;
  logic              dir_q,   dir_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [FLOORS-1:0] below_mask;
  logic [FLOORS-1:0] above_mask;
  logic              req_here;
  logic              req_above;
  logic              req_below;
  logic              btn_here;
  logic              clr_here;

  // One-hot minus one gives every bit strictly below the car.
  assign below_mask = floor_q - FLOORS'(1);
  assign above_mask = ~(floor_q | below_mask);

  assign req_here  = |(pend_q & floor_q);
  assign req_above = |(pend_q & above_mask);
  assign req_below = |(pend_q & below_mask);
  assign btn_here  = |(button & floor_q);

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    clr_here = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_here) begin
          state_d  = S_DOOR;
          timer_d  = T_DOOR;
          clr_here = 1'b1;
        end else if (req_above && (dir_q || !req_below)) begin
          dir_d   = 1'b1;
          state_d = S_MOVE;
          timer_d = T_MOVE;
        end else if (req_below) begin
          dir_d   = 1'b0;
          state_d = S_MOVE;
          timer_d = T_MOVE;
        end
      end

      S_MOVE: begin
        if (timer_q == T_ONE) begin
          floor_d = dir_q ? (floor_q << 1) : (floor_q >> 1);
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      S_DOOR: begin
        clr_here = 1'b1;
        if (btn_here) begin
          timer_d = T_DOOR;
        end else if (timer_q == T_ONE) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // The current floor's call is absorbed on entry to DOOR and for as long as the door is open.
    pend_d = pend_q | button;
    if (clr_here) begin
      pend_d = pend_d & ~floor_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      floor_q <= FLOORS'(1);
      pend_q  <= '0;
      dir_q   <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  assign floor     = floor_q;
  assign pending   = pend_q;
  assign dir_up    = dir_q;
  assign moving    = (state_q == S_MOVE);
  assign door_open = (state_q == S_DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: vector table for cycle-exact behaviour plus
// hand sequences for reset, multi-stop, SCAN reversal and reset mid-move.
module tb_elevator_ctrl;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst    = 1'b0;
  logic [3:0] button = '0;
  logic [3:0] floor;
  logic [3:0] pending;
  logic       dir_up;
  logic       moving;
  logic       door_open;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] fl;
    logic [3:0] pd;
    logic       dr;
    logic       mv;
    logic       dp;
  } vec_t;

  vec_t vq[$];

  elevator_ctrl #(
    .FLOORS     (4),
    .MOVE_CYCLES(4),
    .DOOR_CYCLES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .floor    (floor),
    .pending  (pending),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] f, input logic [3:0] p,
                         input logic d, input logic m, input logic o);
    checks++;
    if ({floor, pending, dir_up, moving, door_open} !== {f, p, d, m, o}) begin
      errors++;
      $display("FAIL %s: got floor=%b pending=%b dir_up=%b moving=%b door_open=%b, want floor=%b pending=%b dir_up=%b moving=%b door_open=%b",
               nm, floor, pending, dir_up, moving, door_open, f, p, d, m, o);
    end
  endtask

  task automatic chk_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic [3:0] f, input logic [3:0] p,
                     input logic d, input logic m, input logic o);
    vec_t v;
    v.btn = b; v.fl = f; v.pd = p; v.dr = d; v.mv = m; v.dp = o;
    vq.push_back(v);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    chk_all(nm, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the door to open, then checks which floor it opened at.
  task automatic wait_door(input logic [3:0] f, input string nm);
    int n = 0;
    while (!door_open && n < 60) begin
      tick();
      n++;
    end
    chk_val({nm, "_open"}, {7'd0, door_open}, 8'd1);
    chk_val({nm, "_floor"}, {4'd0, floor}, {4'd0, f});
  endtask

  task automatic wait_close(output int cycles);
    cycles = 0;
    while (door_open && cycles < 30) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    int  n;
    bit  bad;

    // Asynchronous reset with the clock stopped.
    #3;
    rst = 1'b1;
    #1;
    chk_all("reset_async", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    clk_en = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;

    // Single call to floor 2 from floor 0.
    add(4'b0100, 4'b0001, 4'b0100, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0001, 4'b0100, 1, 1, 0);
    add(4'b0000, 4'b0010, 4'b0100, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0010, 4'b0100, 1, 1, 0);
    add(4'b0000, 4'b0100, 4'b0100, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0100, 4'b0000, 1, 0, 1);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 0);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 0);
    // Call at the current floor held 5 cycles: dwell extends past the last reload.
    add(4'b0100, 4'b0100, 4'b0100, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0100, 4'b0100, 4'b0000, 1, 0, 1);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 1);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 1);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 0);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 0);
    // Down call to floor 0; direction then holds low while idle.
    add(4'b0001, 4'b0100, 4'b0001, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0100, 4'b0001, 0, 1, 0);
    add(4'b0000, 4'b0010, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0010, 4'b0001, 0, 1, 0);
    add(4'b0000, 4'b0001, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0001, 4'b0000, 0, 0, 1);
    add(4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
    add(4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
    // Up call with dir_up low and nothing below; then calls on both sides while dir_up=1.
    add(4'b0010, 4'b0001, 4'b0010, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b0000, 4'b0001, 4'b0010, 1, 1, 0);
    add(4'b0000, 4'b0010, 4'b0010, 1, 0, 0);
    add(4'b0000, 4'b0010, 4'b0000, 1, 0, 1);
    add(4'b1001, 4'b0010, 4'b1001, 1, 0, 1);
    add(4'b0000, 4'b0010, 4'b1001, 1, 0, 1);
    add(4'b0000, 4'b0010, 4'b1001, 1, 0, 0);
    add(4'b0000, 4'b0010, 4'b1001, 1, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      button = vq[i].btn;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].fl, vq[i].pd, vq[i].dr, vq[i].mv, vq[i].dp);
    end
    button = '0;

    // Multi-stop pass: stop at 1, pass 2 without opening, stop at 3.
    do_reset("ms_reset");
    button = 4'b1010;
    tick();
    button = '0;
    wait_door(4'b0010, "ms_stop1");
    chk_val("ms_dir1", {7'd0, dir_up}, 8'd1);
    wait_close(n);
    chk_val("ms_dwell", 8'(n), 8'd3);
    wait_door(4'b1000, "ms_stop3");
    chk_val("ms_dir3", {7'd0, dir_up}, 8'd1);
    wait_close(n);
    chk_all("ms_final", 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0);

    // SCAN reversal: down call arrives mid-move upward; floor 3 served first.
    do_reset("scan_reset");
    button = 4'b0010;
    tick();
    button = '0;
    wait_door(4'b0010, "scan_stop1");
    wait_close(n);
    button = 4'b1000;
    tick();
    button = '0;
    tick();
    tick();
    button = 4'b0001;
    tick();
    button = '0;
    chk_all("scan_latch", 4'b0010, 4'b1001, 1'b1, 1'b1, 1'b0);
    wait_door(4'b1000, "scan_first");
    chk_val("scan_dir3", {7'd0, dir_up}, 8'd1);
    wait_close(n);
    chk_all("scan_idle", 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("scan_rev", 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0);
    wait_door(4'b0001, "scan_floor0");
    chk_val("scan_pend", {4'd0, pending}, 8'd0);
    chk_val("scan_dir0", {7'd0, dir_up}, 8'd0);
    wait_close(n);

    // Reset in the middle of the floor 1 -> 2 move with floor 3 pending.
    do_reset("rm_reset0");
    button = 4'b1000;
    tick();
    button = '0;
    for (int i = 0; i < 7; i++) tick();
    chk_all("rm_pre", 4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rm_async", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (moving || door_open || floor != 4'b0001 || pending != 4'b0000) bad = 1'b1;
    end
    chk_val("rm_no_motion", {7'd0, bad}, 8'd0);
    chk_all("rm_final", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Parametrised elevator controller for an N-floor car: latches floor-call buttons into a pending-request register and serves them in SCAN order (continue in the current direction while requests remain ahead). It drives the one-hot current floor, the door and the motion status. A timed door dwell and a timed per-floor travel delay replace instantaneous floor jumps. It is the core instantiated under the board-level top, between the debounced button inputs and the floor/door indicators.

## Interface
- FLOORS, 4, number of floors (≥2); floor 0 is the lowest
- MOVE_CYCLES, 4, clock cycles of travel per one-floor step (≥1)
- DOOR_CYCLES, 3, clock cycles the door stays open after the last reload (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- button  in  FLOORS  floor-call buttons, level, sampled every rising edge
- floor  out  FLOORS  one-hot current floor
- pending  out  FLOORS  latched outstanding requests
- dir_up  out  1  current/last travel direction (1 = up)
- moving  out  1  high while in MOVE
- door_open  out  1  high while in DOOR

## Operation
- Reset values (asynchronous, immediate, no clock needed): floor = 1 (floor 0), pending = 0, dir_up = 1, moving = 0, door_open = 0, state = IDLE, timer = 0.
- Request latch, every edge: pending <= pending | button. The only exception: the bit of the current floor is cleared on entry to DOOR and is not set while in DOOR.
- States: IDLE (decision, 1 cycle per visit), MOVE, DOOR. All decisions use registered pending only.
- IDLE, evaluated in priority order:
  - (a) pending[cur] set -> DOOR; clear pending[cur]; load timer = DOOR_CYCLES.
  - (b) Request above and (dir_up or none below) -> dir_up = 1, MOVE, timer = MOVE_CYCLES.
  - (c) Request below -> dir_up = 0, MOVE, timer = MOVE_CYCLES.
  - (d) No requests -> stay in IDLE; dir_up holds.
- MOVE: moving = 1; timer decrements each cycle. On the edge where timer = 1, floor shifts one position (left if dir_up, right otherwise) and the state returns to IDLE.
- DOOR: door_open = 1; timer decrements each cycle. button[cur] high reloads timer = DOOR_CYCLES. The edge where timer = 1 with no reload -> IDLE.
- Direction holds through DOOR. It reverses only in IDLE when no requests remain ahead (SCAN).
- Floors passed without a pending bit are not stopped at. A request for a floor is honoured on arrival if its bit is set by the time IDLE samples it.
- Range: floor never shifts past bit 0 or bit FLOORS-1, because MOVE is entered only toward a pending floor.
- Simultaneous events: a button for a floor the car is leaving is latched normally and served on a later pass. Multiple buttons in one cycle are all latched.

## Timing
- Button high at edge e → pending bit visible after e. IDLE acts on it at edge e+1.
- One floor step costs MOVE_CYCLES cycles in MOVE plus 1 IDLE cycle.
- Door dwell is exactly DOOR_CYCLES cycles of door_open when there is no reload. Each reload extends the dwell to DOOR_CYCLES cycles after the last reload edge.
- All outputs are registered; there are no combinational paths from button to any output.
- Asserting rst at any point, including mid-MOVE or mid-DOOR, discards pending and the timer. Operation resumes from IDLE at floor 0 on the first edge after release.

## Test plan
(FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3.)
- Reset: assert rst with clk stopped → floor=0001, pending=0000, dir_up=1, moving=0, door_open=0 immediately.
- Single call: at floor 0 idle, button=0100 for one cycle →
  - pending=0100 next cycle
  - moving high 4 cycles, floor=0010
  - 1 IDLE cycle, moving high 4 more cycles, floor=0100
  - door_open high 3 cycles, pending=0000, then IDLE.
- Call at current floor: at floor 0, button=0001 held for 5 cycles, then released → door_open high until 3 cycles after the last reload edge; pending[0] never remains set; moving stays 0.
- Multi-stop pass: at floor 0, button=1010 in one cycle → car stops at floor 1 (door 3 cycles), passes floor 2 with door_open=0, stops at floor 3; dir_up=1 throughout.
- SCAN reversal: car moving up from floor 1 toward floor 3; button=0001 pulsed mid-MOVE → car serves floor 3 first; dir_up falls in the IDLE after that door; car then travels down to floor 0 and opens the door.
- Reset mid-operation: assert rst during MOVE between floors 1 and 2 with pending=1000 → outputs return to reset values asynchronously; after release, no motion occurs without a new button.
